// File: rtl/sayac_shu_pkg.sv
// sayac_shu_pkg: types and constants shared by the SAYAC shift unit and normalizer.
//   WIDTH   data width
//   CNT_W   signed shift-amount width (negative = left shift)
//   state_t normalizer FSM states
//   neg_amt two's-complement negation of a left-shift count
package sayac_shu_pkg;
   localparam int WIDTH = 16;
   localparam int CNT_W = 5;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   function automatic logic [CNT_W-1:0] neg_amt(input logic [CNT_W-1:0] count);
      return -count;
   endfunction
endpackage

// File: rtl/sayac_norm_unit_if.sv
// sayac_norm_unit_if: request/result bus of the SAYAC normalizer.
//   start, arith, in_val : request (master -> slave)
//   ready, done, out_val, shamt, zero : status and results (slave -> master)
interface sayac_norm_unit_if;
   import sayac_shu_pkg::*;
   logic             start;
   logic             arith;
   logic [WIDTH-1:0] in_val;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] out_val;
   logic [CNT_W-1:0] shamt;
   logic             zero;
   modport master (output start, arith, in_val, input ready, done, out_val, shamt, zero);
   modport slave (input start, arith, in_val, output ready, done, out_val, shamt, zero);
endinterface

// File: rtl/sayac_norm_detect.sv
// sayac_norm_detect: combinational normalization tests on the working value.
//   value, arith    : word under test and mode (1 = sign-preserving)
//   normalized      : top bit set (logical) or top two bits differ (arith)
//   degenerate      : word can never normalize (0, or all-ones in arith mode)
//   top_nibble_zero : upper four bits clear; present only with SAYAC_NORM_FAST_EN
module sayac_norm_detect
   import sayac_shu_pkg::*;
(
   input  logic [WIDTH-1:0] value,
   input  logic             arith,
   output logic             normalized,
   output logic             degenerate
`ifdef SAYAC_NORM_FAST_EN
   , output logic           top_nibble_zero
`endif
);
   assign normalized = arith ? value[WIDTH-1] ^ value[WIDTH-2] : value[WIDTH-1];
   assign degenerate = value == '0 || (arith && value == '1);
`ifdef SAYAC_NORM_FAST_EN
   assign top_nibble_zero = value[WIDTH-1 -: 4] == 4'd0;
`endif
endmodule

// File: rtl/sayac_norm_unit.sv
// sayac_norm_unit: multi-cycle left normalizer returning the shift used as a
// negative amount in the shift unit's signed encoding.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sayac_norm_unit_if.slave request/result bus
// Optional SAYAC_NORM_FAST_EN: logical operands with a clear top nibble move
// four bits per cycle; results are identical, only latency shrinks.
module sayac_norm_unit
   import sayac_shu_pkg::*;
(
   input logic               clk,
   input logic               rst_n,
   sayac_norm_unit_if.slave  bus
);
   state_t           state, next;
   logic [WIDTH-1:0] work;
   logic [CNT_W-1:0] cnt;
   logic             mode, normalized, degenerate, accept, step, big;
`ifdef SAYAC_NORM_FAST_EN
   logic             top_nibble_zero;
`endif
   sayac_norm_detect u_detect (
      .value(work), .arith(mode), .normalized(normalized), .degenerate(degenerate)
`ifdef SAYAC_NORM_FAST_EN
      , .top_nibble_zero(top_nibble_zero)
`endif
   );
   // ready drops during the done pulse so a new request lands the cycle after it
   assign bus.ready = state == IDLE && !bus.done;
   assign accept = bus.start && bus.ready;
   assign step = state == SHIFT && !normalized && !degenerate;
`ifdef SAYAC_NORM_FAST_EN
   // a non-degenerate logical word with a clear top nibble is nonzero below it
   assign big = !mode && top_nibble_zero && cnt <= CNT_W'(11);
`else
   assign big = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = accept ? SHIFT : IDLE;
         SHIFT:   next = step ? SHIFT : DONE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         work        <= '0;
         cnt         <= '0;
         mode        <= 1'b0;
         bus.done    <= 1'b0;
         bus.out_val <= '0;
         bus.shamt   <= '0;
         bus.zero    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (accept) begin
            work     <= bus.in_val;
            mode     <= bus.arith;
            cnt      <= '0;
            bus.zero <= 1'b0;
         end else if (step) begin
            work <= big ? work << 4 : work << 1;
            cnt  <= cnt + (big ? CNT_W'(4) : CNT_W'(1));
         end else if (state == DONE) begin
            // degenerate words never shift, so cnt is 0 and work is the operand
            bus.out_val <= work;
            bus.shamt   <= neg_amt(cnt);
            bus.zero    <= degenerate;
            bus.done    <= 1'b1;
         end
      end
endmodule

// File: tb/tb_sayac_norm_unit.sv
// tb_sayac_norm_unit: scoreboard bench for sayac_norm_unit; expected results are
// queued at request time and popped when done pulses.
module tb_sayac_norm_unit;
   import sayac_shu_pkg::*;
   typedef struct {logic [15:0] v; logic [4:0] s; logic z; int lat;} exp_t;
   typedef struct {logic [15:0] i; logic a; exp_t e;} vec_t;
`ifdef SAYAC_NORM_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   logic        clk = 1'b0, rst_n = 1'b0;
   int          tests = 0, fails = 0;
   exp_t        sb[$];
   exp_t        ex;
   logic [15:0] gv;
   logic [4:0]  gs;
   logic        gz;
   int          gl;
   sayac_norm_unit_if b();
   sayac_norm_unit dut (.clk(clk), .rst_n(rst_n), .bus(b));
   always #5 clk = ~clk;
   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   function automatic exp_t model(input logic [15:0] x, input logic a);
      exp_t e;
      int   k = 0, n = 0;
      e = '{v: x, s: 5'd0, z: 1'b1, lat: 2};
      if (x == 16'h0000 || (a && x == 16'hFFFF)) return e;
      while (a ? x[15] == x[14] : !x[15]) begin
         if (FAST && !a && x[15:12] == 4'd0 && k <= 11) begin x = x << 4; k += 4; end
         else begin x = x << 1; k++; end
         n++;
      end
      e = '{v: x, s: 5'(32 - k), z: 1'b0, lat: n + 2};
      return e;
   endfunction
   task automatic issue(input logic [15:0] v, input logic a, input exp_t e);
      int w = 0;
      @(negedge clk);
      while (!b.ready && w < 50) begin @(negedge clk); w++; end
      b.in_val = v;
      b.arith  = a;
      b.start  = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 b.start = 1'b0;
   endtask
   task automatic collect();
      gl = 0;
      do begin @(posedge clk); #1; gl++; end while (!b.done && gl < 40);
      if (!b.done) gl = -1;
      gv = b.out_val;
      gs = b.shamt;
      gz = b.zero;
      if (sb.size() > 0) ex = sb.pop_front();
      else ex = '{v: 16'hxxxx, s: 5'bx, z: 1'bx, lat: -2};
   endtask
   task automatic test_reset();
      rst_n = 1'b0; b.start = 1'b0; b.arith = 1'b0; b.in_val = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      tests += 5;
      if (b.ready !== 1'b1) begin fails++; $display("FAIL reset ready got=%b exp=1", b.ready); end
      if (b.done !== 1'b0) begin fails++; $display("FAIL reset done got=%b exp=0", b.done); end
      if (b.out_val !== 16'h0) begin fails++; $display("FAIL reset out_val got=%h exp=0000", b.out_val); end
      if (b.shamt !== 5'h0) begin fails++; $display("FAIL reset shamt got=%b exp=00000", b.shamt); end
      if (b.zero !== 1'b0) begin fails++; $display("FAIL reset zero got=%b exp=0", b.zero); end
   endtask
   task automatic test_logical();
      vec_t t[4];
      t[0] = '{16'h0001, 1'b0, '{16'h8000, 5'b10001, 1'b0, FAST ? 8 : 17}};
      t[1] = '{16'h8000, 1'b0, '{16'h8000, 5'b00000, 1'b0, 2}};
      t[2] = '{16'h8000, 1'b1, '{16'h8000, 5'b00000, 1'b0, 2}};
      t[3] = '{16'h00F0, 1'b0, '{16'hF000, 5'b11000, 1'b0, FAST ? 4 : 10}};
      foreach (t[n]) begin
         issue(t[n].i, t[n].a, t[n].e);
         collect();
         tests += 4;
         if (gv !== ex.v) begin fails++; $display("FAIL logical out_val in=%h got=%h exp=%h", t[n].i, gv, ex.v); end
         if (gs !== ex.s) begin fails++; $display("FAIL logical shamt in=%h got=%b exp=%b", t[n].i, gs, ex.s); end
         if (gz !== ex.z) begin fails++; $display("FAIL logical zero in=%h got=%b exp=%b", t[n].i, gz, ex.z); end
         if (gl != ex.lat) begin fails++; $display("FAIL logical latency in=%h got=%0d exp=%0d", t[n].i, gl, ex.lat); end
      end
   endtask
   task automatic test_arith();
      vec_t t[4];
      t[0] = '{16'hFFF0, 1'b1, '{16'h8000, 5'b10101, 1'b0, 13}};
      t[1] = '{16'h0003, 1'b1, '{16'h6000, 5'b10011, 1'b0, 15}};
      t[2] = '{16'h4000, 1'b1, '{16'h4000, 5'b00000, 1'b0, 2}};
      t[3] = '{16'h1234, 1'b0, '{16'h91A0, 5'b11101, 1'b0, 5}};
      foreach (t[n]) begin
         issue(t[n].i, t[n].a, t[n].e);
         collect();
         tests += 4;
         if (gv !== ex.v) begin fails++; $display("FAIL arith out_val in=%h got=%h exp=%h", t[n].i, gv, ex.v); end
         if (gs !== ex.s) begin fails++; $display("FAIL arith shamt in=%h got=%b exp=%b", t[n].i, gs, ex.s); end
         if (gz !== ex.z) begin fails++; $display("FAIL arith zero in=%h got=%b exp=%b", t[n].i, gz, ex.z); end
         if (gl != ex.lat) begin fails++; $display("FAIL arith latency in=%h got=%0d exp=%0d", t[n].i, gl, ex.lat); end
      end
   endtask
   task automatic test_degenerate();
      vec_t t[4];
      t[0] = '{16'h0000, 1'b0, '{16'h0000, 5'b00000, 1'b1, 2}};
      t[1] = '{16'hFFFF, 1'b1, '{16'hFFFF, 5'b00000, 1'b1, 2}};
      t[2] = '{16'hFFFF, 1'b0, '{16'hFFFF, 5'b00000, 1'b0, 2}};
      t[3] = '{16'h0000, 1'b1, '{16'h0000, 5'b00000, 1'b1, 2}};
      foreach (t[n]) begin
         issue(t[n].i, t[n].a, t[n].e);
         collect();
         tests += 4;
         if (gv !== ex.v) begin fails++; $display("FAIL degen out_val in=%h got=%h exp=%h", t[n].i, gv, ex.v); end
         if (gs !== ex.s) begin fails++; $display("FAIL degen shamt in=%h got=%b exp=%b", t[n].i, gs, ex.s); end
         if (gz !== ex.z) begin fails++; $display("FAIL degen zero in=%h got=%b exp=%b", t[n].i, gz, ex.z); end
         if (gl != ex.lat) begin fails++; $display("FAIL degen latency in=%h got=%0d exp=%0d", t[n].i, gl, ex.lat); end
      end
   endtask
   task automatic test_ignore_start();
      int pulses = 0;
      issue(16'h0001, 1'b0, '{16'h8000, 5'b10001, 1'b0, FAST ? 8 : 17});
      repeat (3) @(negedge clk);
      tests++;
      if (b.ready !== 1'b0) begin fails++; $display("FAIL busy ready got=%b exp=0", b.ready); end
      b.start = 1'b1; b.in_val = 16'h00FF; b.arith = 1'b1;
      @(negedge clk) b.start = 1'b0;
      collect();
      gl += 3;
      tests += 4;
      if (gv !== ex.v) begin fails++; $display("FAIL ignore out_val got=%h exp=%h", gv, ex.v); end
      if (gs !== ex.s) begin fails++; $display("FAIL ignore shamt got=%b exp=%b", gs, ex.s); end
      if (gz !== ex.z) begin fails++; $display("FAIL ignore zero got=%b exp=%b", gz, ex.z); end
      if (gl != ex.lat) begin fails++; $display("FAIL ignore latency got=%0d exp=%0d", gl, ex.lat); end
      repeat (25) begin @(posedge clk); #1; if (b.done) pulses++; end
      tests++;
      if (pulses != 0) begin fails++; $display("FAIL ignore extra_done got=%0d exp=0", pulses); end
   endtask
   task automatic test_reset_mid();
      int pulses = 0;
      @(negedge clk);
      b.in_val = 16'h0001; b.arith = 1'b0; b.start = 1'b1;
      @(posedge clk);
      #1 b.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests += 5;
      if (b.ready !== 1'b1) begin fails++; $display("FAIL rstmid ready got=%b exp=1", b.ready); end
      if (b.done !== 1'b0) begin fails++; $display("FAIL rstmid done got=%b exp=0", b.done); end
      if (b.out_val !== 16'h0) begin fails++; $display("FAIL rstmid out_val got=%h exp=0000", b.out_val); end
      if (b.shamt !== 5'h0) begin fails++; $display("FAIL rstmid shamt got=%b exp=00000", b.shamt); end
      if (b.zero !== 1'b0) begin fails++; $display("FAIL rstmid zero got=%b exp=0", b.zero); end
      @(negedge clk) rst_n = 1'b1;
      repeat (25) begin @(posedge clk); #1; if (b.done) pulses++; end
      tests += 2;
      if (pulses != 0) begin fails++; $display("FAIL rstmid done_pulses got=%0d exp=0", pulses); end
      if (b.ready !== 1'b1) begin fails++; $display("FAIL rstmid ready_after got=%b exp=1", b.ready); end
   endtask
   task automatic test_back_to_back();
      logic [15:0] x;
      logic        a;
      for (int n = 0; n < 300; n++) begin
         x = 16'($urandom) >> $urandom_range(0, 16);
         a = 1'($urandom);
         if (n % 37 == 0) x = a ? 16'hFFFF : 16'h0000;
         if (a && n % 3 == 0) x = ~x;
         issue(x, a, model(x, a));
         collect();
         tests += 4;
         if (gv !== ex.v) begin fails++; $display("FAIL random out_val in=%h a=%b got=%h exp=%h", x, a, gv, ex.v); end
         if (gs !== ex.s) begin fails++; $display("FAIL random shamt in=%h a=%b got=%b exp=%b", x, a, gs, ex.s); end
         if (gz !== ex.z) begin fails++; $display("FAIL random zero in=%h a=%b got=%b exp=%b", x, a, gz, ex.z); end
         if (gl != ex.lat) begin fails++; $display("FAIL random latency in=%h a=%b got=%0d exp=%0d", x, a, gl, ex.lat); end
      end
   endtask
   initial begin
      test_reset();
      test_logical();
      test_arith();
      test_degenerate();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL scoreboard leftover got=%0d exp=0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
